// File: rtl/bfly_pkg.sv
// Shared types and constants for the butterfly issue sequencer.
package bfly_pkg;

  localparam int unsigned FP_W      = 32;
  localparam int unsigned ERR_W     = 2;
  localparam int unsigned ERR_UNEXP = 0;
  localparam int unsigned ERR_WDOG  = 1;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } bfly_state_e;

  // Destination tag width for a block of n samples.
  function automatic int unsigned tag_w(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/bfly_tag_fifo.sv
// Destination-tag FIFO: depth 2**W, same-cycle push/pop, synchronous flush.
module bfly_tag_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_c,
  output logic         empty_c,
  output logic         full_c,
  output logic [W:0]   level_c
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] wr_ptr;
  logic [W-1:0] rd_ptr;
  logic [W:0]   level;
  logic         do_push;
  logic         do_pop;

  assign empty_c = (level == '0);
  assign full_c  = (level == (W+1)'(DEPTH));
  assign level_c = level;
  assign head_c  = mem[rd_ptr];

  // A pop frees a slot in the same cycle, so a full FIFO may still accept.
  assign do_push = push && (!full_c || pop);
  assign do_pop  = pop && !empty_c;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (W+1)'(1);
        2'b01:   level <= level - (W+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/bfly_issue_seq.sv
// Butterfly issue sequencer: loads N samples, issues first-stage add/sub pairs,
// collects in-order results and streams them out. Optional watchdog: BFLY_WATCHDOG_EN.
module bfly_issue_seq
  import bfly_pkg::*;
#(
  parameter int unsigned N   = 8,
  parameter int unsigned LAT = 6
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [FP_W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FP_W-1:0] out_data,
  output logic            out_last,
  output logic            fu_stt,
  output logic            fu_op_add,
  output logic [FP_W-1:0] fu_a,
  output logic [FP_W-1:0] fu_b,
  input  logic [FP_W-1:0] fu_result,
  input  logic            fu_result_valid,
  output logic            busy,
  output logic [ERR_W-1:0] err
);

  localparam int unsigned TAG_W = tag_w(N);
  localparam int unsigned LVL_W = TAG_W + 1;
  localparam logic [TAG_W-1:0] LAST_IDX = TAG_W'(N - 1);
  localparam logic [TAG_W-1:0] HALF     = TAG_W'(N / 2);

  bfly_state_e      state;
  logic [TAG_W-1:0] cnt;
  logic [FP_W-1:0]  x [N];
  logic [FP_W-1:0]  y [N];

  logic             load_hs;
  logic             load_last;
  logic [TAG_W-1:0] issue_idx;
  logic [TAG_W-1:0] issue_k;
  logic [TAG_W-1:0] mirror_k;
  logic             push;
  logic [TAG_W-1:0] push_tag;
  logic             pop;
  logic             flush;
  logic [TAG_W-1:0] head;
  logic             fifo_empty;
  logic             unused_full;
  logic [LVL_W-1:0] level;
  logic             drain_done;
  logic             wd_fire;
  logic [FP_W-1:0]  first_word;
  logic [TAG_W-1:0] cnt_inc;

  assign load_hs   = (state == LOAD) && in_valid;
  assign load_last = load_hs && (cnt == LAST_IDX);

  // Issue 0 goes out on the final load edge so fu_stt covers exactly t+1..t+N.
  assign issue_idx = (state == ISSUE) ? cnt : '0;
  assign issue_k   = issue_idx >> 1;
  assign mirror_k  = LAST_IDX - issue_k;
  assign push      = load_last || (state == ISSUE);
  assign push_tag  = issue_idx[0] ? (HALF + issue_k) : issue_k;
  assign pop       = fu_result_valid && !fifo_empty;
  assign flush     = wd_fire;

  // The last pop decides DRAIN->OUT in its own cycle, bypassing the y write.
  assign drain_done = (level == '0) || ((level == LVL_W'(1)) && pop);
  assign first_word = (pop && (head == '0)) ? fu_result : y[0];
  assign cnt_inc    = cnt + TAG_W'(1);

  bfly_tag_fifo #(
    .DEPTH (N),
    .W     (TAG_W)
  ) u_tag_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .push      (push),
    .push_data (push_tag),
    .pop       (pop),
    .head_c    (head),
    .empty_c   (fifo_empty),
    .full_c    (unused_full),
    .level_c   (level)
  );

`ifdef BFLY_WATCHDOG_EN
  localparam int unsigned WD_LIMIT = LAT + 4;
  localparam int unsigned WD_W     = $clog2(WD_LIMIT + 1);

  logic [WD_W-1:0] wd_cnt;

  // Cycles since the last issue or pop, saturating at the limit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
    end else if (push || pop) begin
      wd_cnt <= '0;
    end else if (wd_cnt != WD_W'(WD_LIMIT)) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  assign wd_fire = (state == DRAIN) && !pop && !fifo_empty && (wd_cnt == WD_W'(WD_LIMIT));
`else
  logic unused_lat;
  assign unused_lat = (LAT == 0);
  assign wd_fire    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= LOAD;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      fu_stt    <= 1'b0;
      fu_op_add <= 1'b0;
      fu_a      <= '0;
      fu_b      <= '0;
      busy      <= 1'b0;
      err       <= '0;
      for (int i = 0; i < int'(N); i++) begin
        x[i] <= '0;
        y[i] <= '0;
      end
    end else begin
      if (pop) begin
        y[head] <= fu_result;
      end

      case (state)
        LOAD: begin
          if (in_valid) begin
            x[cnt] <= in_data;
            busy   <= 1'b1;
            if (cnt == '0) begin
              err <= '0;
              for (int i = 0; i < int'(N); i++) begin
                y[i] <= '0;
              end
            end
            if (cnt == LAST_IDX) begin
              state     <= ISSUE;
              cnt       <= TAG_W'(1);
              in_ready  <= 1'b0;
              fu_stt    <= 1'b1;
              fu_op_add <= 1'b1;
              fu_a      <= x[0];
              fu_b      <= in_data;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end

        ISSUE: begin
          fu_stt    <= 1'b1;
          fu_op_add <= ~cnt[0];
          fu_a      <= x[issue_k];
          fu_b      <= x[mirror_k];
          if (cnt == LAST_IDX) begin
            state <= DRAIN;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end

        DRAIN: begin
          fu_stt <= 1'b0;
          if (drain_done || wd_fire) begin
            if (!drain_done) begin
              err[ERR_WDOG] <= 1'b1;
            end
            state     <= OUT;
            cnt       <= '0;
            out_valid <= 1'b1;
            out_data  <= first_word;
            out_last  <= (LAST_IDX == '0);
          end
        end

        OUT: begin
          if (out_ready) begin
            if (cnt == LAST_IDX) begin
              state     <= LOAD;
              cnt       <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
            end else begin
              cnt      <= cnt_inc;
              out_data <= y[cnt_inc];
              out_last <= (cnt_inc == LAST_IDX);
            end
          end
        end

        default: state <= LOAD;
      endcase

      // Results with no outstanding tag are dropped and flagged.
      if (fu_result_valid && fifo_empty) begin
        err[ERR_UNEXP] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bfly_issue_seq.sv
// Self-checking bench for bfly_issue_seq with a behavioural add/sub unit of latency LAT.
module tb_bfly_issue_seq;

  localparam int N   = 8;
  localparam int LAT = 6;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        fu_stt;
  logic        fu_op_add;
  logic [31:0] fu_a;
  logic [31:0] fu_b;
  logic [31:0] fu_result = '0;
  logic        fu_result_valid = 1'b0;
  logic        busy;
  logic [1:0]  err;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int t_edge = 0;

  logic [31:0] xs   [N];
  int          xi   [N];
  logic [31:0] yexp [N];

  bfly_issue_seq #(.N(N), .LAT(LAT)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_last        (out_last),
    .fu_stt          (fu_stt),
    .fu_op_add       (fu_op_add),
    .fu_a            (fu_a),
    .fu_b            (fu_b),
    .fu_result       (fu_result),
    .fu_result_valid (fu_result_valid),
    .busy            (busy),
    .err             (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Exact conversions for small integers (|v| < 2^24) to/from IEEE single.
  function automatic logic [31:0] i2f(input int v);
    logic [31:0] m;
    int e;
    logic s;
    if (v == 0) return 32'h0;
    s = (v < 0);
    m = s ? 32'(-v) : 32'(v);
    e = 31;
    while (m[e] == 1'b0) e--;
    m = m << (23 - e);
    return {s, 8'(127 + e), m[22:0]};
  endfunction

  function automatic int f2i(input logic [31:0] f);
    int e;
    int m;
    if (f[30:23] == 8'h0) return 0;
    e = int'(f[30:23]) - 127;
    m = int'({8'h0, 1'b1, f[22:0]});
    m = m >>> (23 - e);
    return f[31] ? -m : m;
  endfunction

  // Behavioural add/sub: result valid LAT cycles after the cycle stt is seen.
  logic [31:0] rec_d [64];
  logic        rec_v [64];
  int          n_neg       = 0;
  int          issue_seen  = 0;
  int          drop_issue  = -1;
  logic        spur_req    = 1'b0;

  always @(negedge clk) begin
    int s;
    s = n_neg % 64;
    rec_v[s] = 1'b0;
    rec_d[s] = 32'h0;
    if (fu_stt === 1'b1) begin
      if (issue_seen != drop_issue) begin
        rec_v[s] = 1'b1;
        rec_d[s] = fu_op_add ? i2f(f2i(fu_a) + f2i(fu_b)) : i2f(f2i(fu_a) - f2i(fu_b));
      end
      issue_seen++;
    end
    if (n_neg >= LAT) begin
      fu_result_valid = rec_v[(n_neg - LAT) % 64] | spur_req;
      fu_result       = rec_d[(n_neg - LAT) % 64];
    end else begin
      fu_result_valid = spur_req;
    end
    n_neg++;
  end

  // Reference: y[k] = x[k] + x[N-1-k], y[N/2+k] = x[k] - x[N-1-k].
  task automatic ref_model();
    for (int k = 0; k < N / 2; k++) begin
      yexp[k]         = i2f(xi[k] + xi[N-1-k]);
      yexp[N / 2 + k] = i2f(xi[k] - xi[N-1-k]);
    end
  endtask

  task automatic rand_block();
    for (int i = 0; i < N; i++) begin
      xi[i] = int'($urandom_range(2000, 0)) - 1000;
      xs[i] = i2f(xi[i]);
    end
    ref_model();
  endtask

  // Starts and ends at a negedge; t_edge ends up at the count including the final load edge.
  task automatic load_block(input int gap_max);
    for (int i = 0; i < N; i++) begin
      if (gap_max > 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(gap_max, 0)) @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = xs[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    t_edge   = edge_n;
  endtask

  // mode 0: ready held high; 1: random ready; 2: 3-cycle stall at stall_word.
  task automatic collect_block(input int mode, input int stall_word);
    int w = 0;
    int budget = 0;
    int stalls = 0;
    logic r;
    while (w < N && budget < 300) begin
      if (out_valid === 1'b1) begin
        checks++;
        if (out_data !== yexp[w]) begin
          errors++;
          $display("FAIL out_data word %0d: got %h want %h", w, out_data, yexp[w]);
        end
        checks++;
        if (out_last !== (w == N - 1)) begin
          errors++;
          $display("FAIL out_last word %0d: got %b want %b", w, out_last, (w == N - 1));
        end
        if (mode == 1) r = 1'($urandom_range(1, 0));
        else if (mode == 2 && w == stall_word && stalls < 3) begin
          r = 1'b0;
          stalls++;
        end else r = 1'b1;
        out_ready = r;
        if (r) w++;
      end else begin
        out_ready = (mode == 1) ? 1'($urandom_range(1, 0)) : 1'b0;
      end
      @(negedge clk);
      budget++;
    end
    out_ready = 1'b0;
    checks++;
    if (w != N) begin
      errors++;
      $display("FAIL collect words: got %0d want %0d", w, N);
    end
    if (mode == 0) begin
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
        errors++;
        $display("FAIL ready after last: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({in_ready, out_valid, out_data, out_last, fu_stt, fu_op_add, fu_a, fu_b, busy, err} !==
        {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL reset outputs: got in_ready=%b out_valid=%b out_data=%h fu_stt=%b fu_a=%h fu_b=%h busy=%b err=%b want 1 0 0 0 0 0 0 0",
               in_ready, out_valid, out_data, fu_stt, fu_a, fu_b, busy, err);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, busy, err, out_valid} !== 5'b10000) begin
      errors++;
      $display("FAIL idle after reset: got in_ready=%b busy=%b err=%b out_valid=%b want 1 0 00 0",
               in_ready, busy, err, out_valid);
    end
  endtask

  task automatic test_nominal();
    logic [65:0] got;
    logic [65:0] want;
    xs   = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
             32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    yexp = '{32'h41100000, 32'h41100000, 32'h41100000, 32'h41100000,
             32'hC0E00000, 32'hC0A00000, 32'hC0400000, 32'hBF800000};
    load_block(0);
    for (int k = 0; k <= 14; k++) begin
      got = {fu_stt, fu_op_add, fu_a, fu_b};
      if (k < N) begin
        want = {1'b1, (k % 2 == 0), xs[k / 2], xs[N - 1 - k / 2]};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL issue %0d: got %h want %h", k, got, want);
        end
      end else if (k == N) begin
        want = {1'b0, 1'b0, xs[3], xs[4]};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL issue idle hold: got %h want %h", got, want);
        end
      end
      if (k == 13 || k == 14) begin
        checks++;
        if (out_valid !== (k == 14)) begin
          errors++;
          $display("FAIL out_valid latency +%0d: got %b want %b", k + 1, out_valid, (k == 14));
        end
      end
      if (k < 14) @(negedge clk);
    end
    checks++;
    if (edge_n - t_edge != 14) begin
      errors++;
      $display("FAIL latency edges: got %0d want 14", edge_n - t_edge);
    end
    collect_block(0, -1);
    checks++;
    if (err !== 2'b00) begin
      errors++;
      $display("FAIL nominal err: got %b want 00", err);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < N; i++) begin
      xi[i] = i + 1;
      xs[i] = i2f(xi[i]);
    end
    ref_model();
    load_block(0);
    collect_block(2, 1);
  endtask

  task automatic test_spurious();
    @(posedge clk);
    #1 spur_req = 1'b1;
    @(posedge clk);
    #1 spur_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({err, in_ready, busy} !== 4'b0110) begin
      errors++;
      $display("FAIL spurious: got err=%b in_ready=%b busy=%b want 01 1 0", err, in_ready, busy);
    end
    rand_block();
    load_block(2);
    checks++;
    if (err !== 2'b00) begin
      errors++;
      $display("FAIL err clear on load: got %b want 00", err);
    end
    collect_block(1, -1);
  endtask

  task automatic test_reset_mid_issue();
    rand_block();
    load_block(0);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, fu_stt, fu_a, fu_b, busy, err} !== {1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL mid-issue reset: got in_ready=%b out_valid=%b fu_stt=%b fu_a=%h busy=%b err=%b want 1 0 0 0 0 00",
               in_ready, out_valid, fu_stt, fu_a, busy, err);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    checks++;
    if ({err, in_ready, busy} !== 4'b0110) begin
      errors++;
      $display("FAIL stale results: got err=%b in_ready=%b busy=%b want 01 1 0", err, in_ready, busy);
    end
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 4; b++) begin
      rand_block();
      load_block((b == 0) ? 0 : 3);
      collect_block((b % 2 == 0) ? 0 : 1, -1);
      checks++;
      if (err !== 2'b00) begin
        errors++;
        $display("FAIL block %0d err: got %b want 00", b, err);
      end
    end
  endtask

  task automatic test_watchdog();
    rand_block();
    @(posedge clk);
    #1 drop_issue = issue_seen + 7;
    @(negedge clk);
    load_block(0);
`ifdef BFLY_WATCHDOG_EN
    yexp[N - 1] = 32'h0;
    collect_block(0, -1);
    checks++;
    if (err !== 2'b10) begin
      errors++;
      $display("FAIL watchdog err: got %b want 10", err);
    end
`else
    repeat (60) @(negedge clk);
    checks++;
    if ({busy, out_valid, fu_stt, in_ready} !== 4'b1000) begin
      errors++;
      $display("FAIL drain hang: got busy=%b out_valid=%b fu_stt=%b in_ready=%b want 1 0 0 0",
               busy, out_valid, fu_stt, in_ready);
    end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({err, busy, in_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL recover after hang: got err=%b busy=%b in_ready=%b want 00 0 1", err, busy, in_ready);
    end
`endif
    drop_issue = -1;
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_nominal();
    test_backpressure();
    test_spurious();
    test_back_to_back();
    test_reset_mid_issue();
    test_watchdog();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
